// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the memory-access stage: data-access and write-back
// selects, bus FSM states and the fill word returned on an access timeout.
package cpu_defs;

  localparam logic [1:0] DRW_NONE = 2'b00;
  localparam logic [1:0] DRW_RD   = 2'b01;
  localparam logic [1:0] DRW_WR   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } bus_state_t;

  localparam logic [31:0] TIMEOUT_FILL = 32'hdeadbeef;

  function automatic logic is_access(input logic [1:0] drw);
    return (drw == DRW_RD) || (drw == DRW_WR);
  endfunction

endpackage

// File: rtl/cpu_mem_bus_if.sv
// Data-bus sequencer: issues one req/ack transaction per access, holds the
// pipeline while it is outstanding and captures the returned word in rbuf.
module cpu_mem_bus_if
  import cpu_defs::*;
#(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_acc,
  input  logic        i_ext_stall,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_we,
  output logic        d_req,
  input  logic [31:0] d_rdata,
  input  logic        d_ack,
  output logic [31:0] o_rbuf,
  output logic        o_mem_stall,
  output logic        o_bus_err
);

  // Counter only needs to reach ACK_TIMEOUT-1; the last waiting cycle triggers the timeout.
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  bus_state_t    r_state, w_state_next;
  logic [31:0]   r_addr, w_addr_next;
  logic [31:0]   r_wdata, w_wdata_next;
  logic          r_we, w_we_next;
  logic          r_req, w_req_next;
  logic [31:0]   r_rbuf, w_rbuf_next;
  logic          r_err, w_err_next;
  logic [CW-1:0] r_cnt, w_cnt_next;

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_we_next    = r_we;
    w_req_next   = r_req;
    w_rbuf_next  = r_rbuf;
    w_err_next   = 1'b0;
    w_cnt_next   = r_cnt;
    o_mem_stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_mem_stall = i_acc;
        if (i_acc && !i_ext_stall) begin
          w_addr_next  = {i_addr[31:2], 2'b00};
          w_wdata_next = i_wdata;
          w_we_next    = i_we;
          w_req_next   = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        o_mem_stall = 1'b1;
        if (d_ack) begin
          w_rbuf_next  = d_rdata;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_state_next = S_DONE;
        end else if ((ACK_TIMEOUT > 0) && (r_cnt == CNT_LAST)) begin
          w_rbuf_next  = TIMEOUT_FILL;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        // Pipeline advances out of DONE only when nobody else holds it.
        if (!i_ext_stall) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_req   <= 1'b0;
      r_rbuf  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_we    <= w_we_next;
      r_req   <= w_req_next;
      r_rbuf  <= w_rbuf_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign d_addr    = r_addr;
  assign d_wdata   = r_wdata;
  assign d_we      = r_we;
  assign d_req     = r_req;
  assign o_rbuf    = r_rbuf;
  assign o_bus_err = r_err;

endmodule

// File: rtl/cpu_mem.sv
// Memory-access pipeline stage: store-data forwarding, bus sequencing and the
// MEM/WB pipeline registers that also feed EX forwarding.
module cpu_mem
  import cpu_defs::*;
#(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_stall,
  input  logic        ex_c_rfw,
  input  logic [1:0]  ex_c_wbsource,
  input  logic [1:0]  ex_c_drw,
  input  logic [31:0] ex_alu_r,
  input  logic [31:0] ex_rfb,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_jalra,
  input  logic [4:0]  ex_rt,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_we,
  output logic        d_req,
  input  logic [31:0] d_rdata,
  input  logic        d_ack,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        m_c_rfw,
  output logic [4:0]  m_rf_waddr,
  output logic [31:0] m_wdata
);

  logic        w_acc;
  logic        w_fwd;
  logic [31:0] w_sdata;
  logic [31:0] w_rbuf;
  logic        w_mem_stall;
  logic        w_advance;
  logic [31:0] w_wb_data;

  logic        r_m_c_rfw;
  logic [4:0]  r_m_rf_waddr;
  logic [31:0] r_m_wdata;

  assign w_acc = is_access(ex_c_drw);

  // A load immediately followed by a store of the same register takes the loaded word.
  assign w_fwd   = r_m_c_rfw && (r_m_rf_waddr == ex_rt) && (r_m_rf_waddr != 5'd0);
  assign w_sdata = w_fwd ? r_m_wdata : ex_rfb;

  cpu_mem_bus_if #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_bus_if (
    .clk         (clk),
    .rst         (rst),
    .i_acc       (w_acc),
    .i_ext_stall (ext_stall),
    .i_addr      (ex_alu_r),
    .i_wdata     (w_sdata),
    .i_we        (ex_c_drw[1]),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_we        (d_we),
    .d_req       (d_req),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .o_rbuf      (w_rbuf),
    .o_mem_stall (w_mem_stall),
    .o_bus_err   (bus_err)
  );

  assign w_advance = !(ext_stall | w_mem_stall);

  always_comb begin
    w_wb_data = ex_alu_r;
    case (ex_c_wbsource)
      WB_MEM:  w_wb_data = w_rbuf;
      WB_LINK: w_wb_data = ex_jalra;
      default: w_wb_data = ex_alu_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_c_rfw    <= 1'b0;
      r_m_rf_waddr <= '0;
      r_m_wdata    <= '0;
    end else if (w_advance) begin
      r_m_c_rfw    <= ex_c_rfw;
      r_m_rf_waddr <= ex_rf_waddr;
      r_m_wdata    <= w_wb_data;
    end
  end

  assign mem_stall  = w_mem_stall;
  assign m_c_rfw    = r_m_c_rfw;
  assign m_rf_waddr = r_m_rf_waddr;
  assign m_wdata    = r_m_wdata;

endmodule

// File: tb/tb_cpu_mem.sv
// Self-checking bench for cpu_mem: directed scenarios plus randomized
// instructions, checked every cycle against an instruction-level model.
module tb_cpu_mem;

  localparam int TO = 4;
  localparam logic [31:0] FILL = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_stall;
  logic        ex_c_rfw;
  logic [1:0]  ex_c_wbsource;
  logic [1:0]  ex_c_drw;
  logic [31:0] ex_alu_r;
  logic [31:0] ex_rfb;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_jalra;
  logic [4:0]  ex_rt;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_req;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_stall;
  logic        bus_err;
  logic        m_c_rfw;
  logic [4:0]  m_rf_waddr;
  logic [31:0] m_wdata;

  cpu_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_stall     (ext_stall),
    .ex_c_rfw      (ex_c_rfw),
    .ex_c_wbsource (ex_c_wbsource),
    .ex_c_drw      (ex_c_drw),
    .ex_alu_r      (ex_alu_r),
    .ex_rfb        (ex_rfb),
    .ex_rf_waddr   (ex_rf_waddr),
    .ex_jalra      (ex_jalra),
    .ex_rt         (ex_rt),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_we          (d_we),
    .d_req         (d_req),
    .d_rdata       (d_rdata),
    .d_ack         (d_ack),
    .mem_stall     (mem_stall),
    .bus_err       (bus_err),
    .m_c_rfw       (m_c_rfw),
    .m_rf_waddr    (m_rf_waddr),
    .m_wdata       (m_wdata)
  );

  always #5 clk = ~clk;

  // Expectations and model state, written by the driver only
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_err, exp_we;
  logic [31:0] exp_addr, exp_wd;
  logic        mod_rfw;
  logic [4:0]  mod_waddr;
  logic [31:0] mod_wdata;
  logic [31:0] last_rbuf;
  int          exp_txn = 0;
  bit          lit_valid = 1'b0;
  int          lit_sel;
  logic [31:0] lit_exp;
  string       lit_name;
  bit          pend_valid = 1'b0;
  int          pend_sel;
  logic [31:0] pend_exp;
  string       pend_name;
  logic [31:0] mem [logic [29:0]];
  int          instr_no = 0;

  // Written by the compare process only
  int          chk_cnt = 0;
  int          err_cnt = 0;
  int          txn_total = 0;
  logic        prev_req = 1'b0;
  logic [31:0] lit_act;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (d_req === 1'b1 && !prev_req) txn_total++;
      prev_req = (d_req === 1'b1);
      if (chk_en) begin
        chk("mem_stall",  32'(mem_stall), 32'(exp_stall));
        chk("d_req",      32'(d_req),     32'(exp_req));
        chk("bus_err",    32'(bus_err),   32'(exp_err));
        chk("m_c_rfw",    32'(m_c_rfw),   32'(mod_rfw));
        chk("m_rf_waddr", 32'(m_rf_waddr), 32'(mod_waddr));
        chk("m_wdata",    m_wdata,        mod_wdata);
        chk("txn_count",  32'(txn_total), 32'(exp_txn));
        if (exp_req) begin
          chk("d_addr",  d_addr,      exp_addr);
          chk("d_wdata", d_wdata,     exp_wd);
          chk("d_we",    32'(d_we),   32'(exp_we));
        end
        if (lit_valid) begin
          case (lit_sel)
            0:       lit_act = m_wdata;
            1:       lit_act = d_addr;
            2:       lit_act = d_wdata;
            3:       lit_act = {27'd0, m_rf_waddr};
            default: lit_act = {31'd0, m_c_rfw};
          endcase
          chk(lit_name, lit_act, lit_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got running want finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rd_mem(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w, 2'b00} ^ 32'h5a5a_a5a5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  task automatic set_lit(input int sel, input string name, input logic [31:0] v);
    lit_valid = 1'b1;
    lit_sel   = sel;
    lit_name  = name;
    lit_exp   = v;
  endtask

  task automatic set_pend(input int sel, input string name, input logic [31:0] v);
    pend_valid = 1'b1;
    pend_sel   = sel;
    pend_name  = name;
    pend_exp   = v;
  endtask

  task automatic drive_ex(input logic rfw, input logic [1:0] wbs, input logic [1:0] drw,
                          input logic [31:0] alu, input logic [31:0] rfb, input logic [4:0] waddr,
                          input logic [31:0] jalra, input logic [4:0] rt);
    ex_c_rfw      = rfw;
    ex_c_wbsource = wbs;
    ex_c_drw      = drw;
    ex_alu_r      = alu;
    ex_rfb        = rfb;
    ex_rf_waddr   = waddr;
    ex_jalra      = jalra;
    ex_rt         = rt;
  endtask

  // One instruction from presentation until the pipeline accepts it.
  task automatic run_instr(input logic rfw, input logic [1:0] wbs, input logic [1:0] drw,
                           input logic [31:0] alu, input logic [31:0] rfb, input logic [4:0] waddr,
                           input logic [31:0] jalra, input logic [4:0] rt,
                           input int pre, input int wt, input bit no_ack, input int dstall);
    bit          acc;
    logic [31:0] sdata;
    logic [31:0] ack_data;
    int          nbusy;
    acc   = (drw == 2'b01) || (drw == 2'b10);
    sdata = (mod_rfw && mod_waddr == rt && mod_waddr != 5'd0) ? mod_wdata : rfb;
    drive_ex(rfw, wbs, drw, alu, rfb, waddr, jalra, rt);
    d_ack   = 1'b0;
    exp_err = 1'b0;
    exp_req = 1'b0;
    if (acc) begin
      for (int i = 0; i < pre; i++) begin
        ext_stall = 1'b1; exp_stall = 1'b1;
        step();
      end
      ext_stall = 1'b0; exp_stall = 1'b1;
      step();
      exp_txn++;
      exp_req  = 1'b1;
      exp_addr = {alu[31:2], 2'b00};
      exp_wd   = sdata;
      exp_we   = drw[1];
      ack_data = drw[1] ? $urandom : rd_mem(alu[31:2]);
      nbusy    = no_ack ? TO : wt + 1;
      for (int i = 0; i < nbusy; i++) begin
        ext_stall = 1'($urandom_range(0, 1));
        d_ack     = !no_ack && (i == wt);
        d_rdata   = d_ack ? ack_data : $urandom;
        if (i == 0 && pend_valid) begin
          set_lit(pend_sel, pend_name, pend_exp);
          pend_valid = 1'b0;
        end
        step();
      end
      d_ack     = 1'b0;
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      last_rbuf = no_ack ? FILL : ack_data;
      if (drw[1] && !no_ack) mem[alu[31:2]] = sdata;
      for (int j = 0; j < dstall; j++) begin
        ext_stall = 1'b1;
        exp_err   = no_ack && (j == 0);
        step();
      end
      ext_stall = 1'b0;
      exp_err   = no_ack && (dstall == 0);
      step();
      exp_err = 1'b0;
    end else begin
      exp_stall = 1'b0;
      for (int i = 0; i < pre; i++) begin
        ext_stall = 1'b1;
        step();
      end
      ext_stall = 1'b0;
      step();
    end
    mod_rfw   = rfw;
    mod_waddr = waddr;
    mod_wdata = (wbs == 2'd1) ? last_rbuf : (wbs == 2'd2) ? jalra : alu;
    $display("instr %0d drw=%b addr=%h wb=%0d rd=%0d timeout=%0d -> m_wdata=%h",
             instr_no, drw, alu, wbs, waddr, no_ack, mod_wdata);
    instr_no++;
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0; d_ack = 1'b0; d_rdata = '0;
    drive_ex(1'b0, 2'd0, 2'b00, '0, '0, '0, '0, '0);
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_wd = '0;
    mod_rfw = 1'b0; mod_waddr = '0; mod_wdata = '0; last_rbuf = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state, then a nop
    set_lit(0, "reset_m_wdata", 32'h0);
    run_instr(1'b0, 2'd0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 0, 0, 1'b0, 0);

    // Load, ack in the first BUSY cycle, misaligned address
    mem[30'h0400_0001] = 32'h1234_5678;
    set_pend(1, "load_d_addr", 32'h1000_0004);
    run_instr(1'b1, 2'd1, 2'b01, 32'h1000_0006, 32'h0, 5'd8, 32'h0, 5'd0, 0, 0, 1'b0, 0);
    set_lit(0, "load_m_wdata", 32'h1234_5678);

    // Store with 3 BUSY cycles
    set_pend(2, "store_d_wdata", 32'hCAFE_F00D);
    run_instr(1'b0, 2'd0, 2'b10, 32'h1000_0010, 32'hCAFE_F00D, 5'd0, 32'h0, 5'd3, 0, 2, 1'b0, 0);
    set_lit(4, "store_m_c_rfw", 32'h0);

    // Load r9 then store r9: forwarded store data
    mem[30'h40] = 32'hA5A5_A5A5;
    run_instr(1'b1, 2'd1, 2'b01, 32'h0000_0100, 32'h0, 5'd9, 32'h0, 5'd0, 0, 0, 1'b0, 0);
    set_pend(2, "fwd_d_wdata", 32'hA5A5_A5A5);
    run_instr(1'b0, 2'd0, 2'b10, 32'h0000_0200, 32'h1111_1111, 5'd0, 32'h0, 5'd9, 0, 1, 1'b0, 0);
    run_instr(1'b1, 2'd0, 2'b00, 32'h0000_0077, 32'h0, 5'd0, 32'h0, 5'd0, 0, 0, 1'b0, 0);
    set_pend(2, "nofwd_r0_d_wdata", 32'h2222_2222);
    run_instr(1'b0, 2'd0, 2'b10, 32'h0000_0204, 32'h2222_2222, 5'd0, 32'h0, 5'd0, 0, 0, 1'b0, 0);

    // jal then ALU pass-through on consecutive cycles
    run_instr(1'b1, 2'd2, 2'b00, 32'h0000_0055, 32'h0, 5'd31, 32'h0000_0108, 5'd0, 0, 0, 1'b0, 0);
    set_lit(0, "jal_m_wdata", 32'h0000_0108);
    run_instr(1'b1, 2'd0, 2'b00, 32'h0000_0007, 32'h0, 5'd4, 32'h0, 5'd0, 0, 0, 1'b0, 0);
    set_lit(0, "alu_m_wdata", 32'h0000_0007);

    // Timeout with ext_stall held in DONE
    run_instr(1'b1, 2'd1, 2'b01, 32'h0000_0300, 32'h0, 5'd5, 32'h0, 5'd0, 0, 0, 1'b1, 2);
    set_lit(0, "timeout_m_wdata", 32'hdead_beef);
    run_instr(1'b0, 2'd0, 2'b00, 32'h0000_0001, 32'h0, 5'd0, 32'h0, 5'd0, 0, 0, 1'b0, 0);

    // Reset during BUSY, late ack ignored
    drive_ex(1'b1, 2'd1, 2'b01, 32'h0000_0400, 32'h0, 5'd6, 32'h0, 5'd0);
    ext_stall = 1'b0; exp_stall = 1'b1; exp_req = 1'b0;
    step();
    exp_txn++;
    exp_req = 1'b1; exp_addr = 32'h0000_0400; exp_wd = 32'h0; exp_we = 1'b0;
    step();
    rst = 1'b1; chk_en = 1'b0;
    step();
    rst = 1'b0; chk_en = 1'b1;
    drive_ex(1'b0, 2'd0, 2'b00, '0, '0, '0, '0, '0);
    d_ack = 1'b1; d_rdata = 32'h9999_9999;
    mod_rfw = 1'b0; mod_waddr = '0; mod_wdata = '0; last_rbuf = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
    set_lit(3, "rst_m_rf_waddr", 32'h0);
    step();
    d_ack = 1'b0;
    run_instr(1'b1, 2'd1, 2'b01, 32'h0000_0400, 32'h0, 5'd6, 32'h0, 5'd0, 1, 1, 1'b0, 1);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      int          r;
      logic [1:0]  drw, wbs;
      logic [4:0]  rt;
      r   = $urandom_range(0, 9);
      drw = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r == 7) ? 2'b11 : 2'b00;
      wbs = (drw == 2'b01 && $urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
      rt  = ($urandom_range(0, 2) == 0) ? mod_waddr : 5'($urandom);
      run_instr(1'($urandom), wbs, drw, 32'h2000_0000 | ($urandom & 32'h3F), $urandom,
                5'($urandom), $urandom, rt, $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
    end

    run_instr(1'b0, 2'd0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 0, 0, 1'b0, 0);
    chk_en = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
